// File: rtl/mips16_pkg.sv
// Shared constants and types for the MIPS16 instruction-memory path.
// Holds the loader FSM state encoding, the default frame sync byte and the
// instruction memory geometry used by both the loader and the CPU imem.
package mips16_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WORD_W     = 16;
   localparam int unsigned IMEM_DEPTH = 16;
   localparam int unsigned IMEM_AW    = 4;

   localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_HI    = 3'd2,
      ST_LO    = 3'd3,
      ST_CKSUM = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_e;

endpackage

// File: rtl/mips16_prog_loader_if.sv
// Byte-serial valid/ready stream feeding the program loader.
//   in_data  : stream byte (master -> slave)
//   in_valid : in_data valid this cycle (master -> slave)
//   in_ready : slave accepts a byte this cycle (slave -> master)
// A byte transfers on a clk edge where in_valid && in_ready.
interface mips16_prog_loader_if;
   import mips16_pkg::*;

   logic [BYTE_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/mips16_byte_pair.sv
// Assembles a hi byte and a following lo byte into one 16-bit word and
// raises word_valid for one cycle, the cycle after the lo byte is taken.
//   clk, rst   : clock, synchronous active-high reset
//   in_byte    : byte being captured
//   hi_we      : capture in_byte as word[15:8]
//   lo_we      : in_byte is word[7:0]; publish {hi, lo} next cycle
//   word       : assembled word (holds last value between pulses)
//   word_valid : one-cycle strobe accompanying a fresh word
module mips16_byte_pair
   import mips16_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] in_byte,
   input  logic              hi_we,
   input  logic              lo_we,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   logic [BYTE_W-1:0] hi_q, hi_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              word_valid_q, word_valid_d;

   // Next-state for the hi latch and the output word
   always_comb begin
      hi_d         = hi_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      if (hi_we) begin
         hi_d = in_byte;
      end
      if (lo_we) begin
         word_d       = {hi_q, in_byte};
         word_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q         <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         hi_q         <= hi_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;

endmodule

// File: rtl/mips16_prog_loader.sv
// Byte-serial program loader: write side of the CPU instruction memory.
// Frame: SYNC, N, then N words as hi/lo byte pairs, then (with
// LOADER_CKSUM_EN defined) one XOR checksum byte over the payload bytes.
// Holds the CPU in reset until a good frame lands or skip is seen in IDLE.
//   clk, rst     : clock, synchronous active-high reset
//   in_if        : byte stream (slave side of valid/ready)
//   skip         : in IDLE, release the CPU without loading
//   mem_we       : instruction memory write strobe (one-cycle pulse)
//   mem_waddr    : word address of the write
//   mem_wdata    : instruction word to write
//   cpu_hold     : CPU reset request, active-high
//   load_done    : image accepted, sticky until a new frame starts
//   load_err     : frame error, sticky until a new sync byte
//   words_loaded : words written in the current frame
// Optional build macro: LOADER_CKSUM_EN (adds the trailing checksum byte).
module mips16_prog_loader
   import mips16_pkg::*;
#(
   parameter int unsigned       DEPTH     = IMEM_DEPTH,
   parameter int unsigned       AW        = IMEM_AW,
   parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   mips16_prog_loader_if.slave  in_if,
   input  logic                 skip,
   output logic                 mem_we,
   output logic [AW-1:0]        mem_waddr,
   output logic [WORD_W-1:0]    mem_wdata,
   output logic                 cpu_hold,
   output logic                 load_done,
   output logic                 load_err,
   output logic [AW:0]          words_loaded
);

   localparam int unsigned CNT_W = AW + 1;
   localparam int unsigned CMP_W = BYTE_W + 1;

   state_e            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  words_q, words_d;
   logic [AW-1:0]     waddr_q, waddr_d;
`ifdef LOADER_CKSUM_EN
   logic [BYTE_W-1:0] cksum_q, cksum_d;
`endif

   logic hi_we;
   logic lo_we;
   logic acc;
   logic is_sync;
   logic n_bad;
   logic last_word;

   assign acc       = in_if.in_valid & in_ready_q;
   assign is_sync   = (in_if.in_data == SYNC_BYTE);
   // Count byte must be 1..DEPTH; compare one bit wider so DEPTH=256 fits
   assign n_bad     = (in_if.in_data == '0) ||
                      (CMP_W'(in_if.in_data) > CMP_W'(DEPTH));
   assign last_word = ((words_q + CNT_W'(1)) == n_q);

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      in_ready_d  = 1'b1;
      cpu_hold_d  = cpu_hold_q;
      load_done_d = load_done_q;
      load_err_d  = load_err_q;
      n_d         = n_q;
      words_d     = words_q;
      waddr_d     = waddr_q;
      hi_we       = 1'b0;
      lo_we       = 1'b0;
`ifdef LOADER_CKSUM_EN
      cksum_d     = cksum_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (skip) begin
               state_d     = ST_DONE;
               cpu_hold_d  = 1'b0;
               load_done_d = 1'b1;
            end else if (acc && is_sync) begin
               state_d = ST_COUNT;
            end
         end

         ST_COUNT: begin
            if (acc) begin
               if (n_bad) begin
                  state_d    = ST_ERR;
                  cpu_hold_d = 1'b1;
                  load_err_d = 1'b1;
               end else begin
                  state_d = ST_HI;
                  n_d     = CNT_W'(in_if.in_data);
                  words_d = '0;
`ifdef LOADER_CKSUM_EN
                  cksum_d = '0;
`endif
               end
            end
         end

         ST_HI: begin
            if (acc) begin
               state_d = ST_LO;
               hi_we   = 1'b1;
`ifdef LOADER_CKSUM_EN
               cksum_d = cksum_q ^ in_if.in_data;
`endif
            end
         end

         ST_LO: begin
            if (acc) begin
               lo_we   = 1'b1;
               waddr_d = words_q[AW-1:0];
               words_d = words_q + CNT_W'(1);
`ifdef LOADER_CKSUM_EN
               cksum_d = cksum_q ^ in_if.in_data;
               state_d = last_word ? ST_CKSUM : ST_HI;
`else
               if (last_word) begin
                  // Release lands on the same cycle as the final write strobe
                  state_d     = ST_DONE;
                  cpu_hold_d  = 1'b0;
                  load_done_d = 1'b1;
               end else begin
                  state_d = ST_HI;
               end
`endif
            end
         end

`ifdef LOADER_CKSUM_EN
         ST_CKSUM: begin
            if (acc) begin
               if (in_if.in_data == cksum_q) begin
                  state_d     = ST_DONE;
                  cpu_hold_d  = 1'b0;
                  load_done_d = 1'b1;
               end else begin
                  state_d    = ST_ERR;
                  cpu_hold_d = 1'b1;
                  load_err_d = 1'b1;
               end
            end
         end
`endif

         ST_DONE: begin
            if (acc && is_sync) begin
               state_d     = ST_COUNT;
               cpu_hold_d  = 1'b1;
               load_done_d = 1'b0;
               load_err_d  = 1'b0;
            end
         end

         ST_ERR: begin
            if (acc && is_sync) begin
               state_d    = ST_COUNT;
               load_err_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         cpu_hold_q  <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         n_q         <= '0;
         words_q     <= '0;
         waddr_q     <= '0;
`ifdef LOADER_CKSUM_EN
         cksum_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         cpu_hold_q  <= cpu_hold_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
         n_q         <= n_d;
         words_q     <= words_d;
         waddr_q     <= waddr_d;
`ifdef LOADER_CKSUM_EN
         cksum_q     <= cksum_d;
`endif
      end
   end

   // Word assembly; its registered strobe and word become the memory port
   mips16_byte_pair u_byte_pair (
      .clk        (clk),
      .rst        (rst),
      .in_byte    (in_if.in_data),
      .hi_we      (hi_we),
      .lo_we      (lo_we),
      .word       (mem_wdata),
      .word_valid (mem_we)
   );

   assign in_if.in_ready = in_ready_q;
   assign mem_waddr      = waddr_q;
   assign cpu_hold       = cpu_hold_q;
   assign load_done      = load_done_q;
   assign load_err       = load_err_q;
   assign words_loaded   = words_q;

endmodule

// File: tb/tb_mips16_prog_loader.sv
// Directed bench for mips16_prog_loader; follows LOADER_CKSUM_EN if defined.
module tb_mips16_prog_loader;
   import mips16_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        skip = 1'b0;
   logic        mem_we;
   logic [3:0]  mem_waddr;
   logic [15:0] mem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   logic [4:0]  words_loaded;

   mips16_prog_loader_if ifc ();

   mips16_prog_loader dut (
      .clk          (clk),
      .rst          (rst),
      .in_if        (ifc),
      .skip         (skip),
      .mem_we       (mem_we),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          wr_cnt  = 0;
   logic [3:0]  wr_addr [0:63];
   logic [15:0] wr_data [0:63];
   logic [7:0]  fr [0:39];

   // Write logger
   always @(negedge clk) begin
      if (mem_we) begin
         if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = mem_waddr;
            wr_data[wr_cnt] = mem_wdata;
         end
         wr_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      ifc.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      ifc.in_data  = b;
      ifc.in_valid = 1'b1;
      t = 0;
      while (!ifc.in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!ifc.in_ready) check("in_ready_timeout", 32'(ifc.in_ready), 32'd1);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
   endtask

   task automatic send_frame(input int len, input int gap);
      for (int i = 0; i < len; i++) send_byte(fr[i], gap);
   endtask

   task automatic set_nominal(input logic [7:0] ck, output int len);
      fr[0] = 8'hA5; fr[1] = 8'h02;
      fr[2] = 8'h01; fr[3] = 8'h23; fr[4] = 8'h45; fr[5] = 8'h67;
`ifdef LOADER_CKSUM_EN
      fr[6] = ck;
      len = 7;
`else
      len = (ck == 8'h00) ? 6 : 6;
`endif
   endtask

   task automatic check_status(input string tag, input logic h, input logic d, input logic e);
      check({tag, "_hold"}, 32'(cpu_hold), 32'(h));
      check({tag, "_done"}, 32'(load_done), 32'(d));
      check({tag, "_err"}, 32'(load_err), 32'(e));
   endtask

   task automatic check_nominal(input string tag, input int base);
      check({tag, "_nwr"}, 32'(wr_cnt - base), 32'd2);
      check({tag, "_a0"}, 32'(wr_addr[base]), 32'h0);
      check({tag, "_d0"}, 32'(wr_data[base]), 32'h0123);
      check({tag, "_a1"}, 32'(wr_addr[base+1]), 32'h1);
      check({tag, "_d1"}, 32'(wr_data[base+1]), 32'h4567);
      check({tag, "_words"}, 32'(words_loaded), 32'd2);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rdy"}, 32'(ifc.in_ready), 32'd0);
      check({tag, "_we"}, 32'(mem_we), 32'd0);
      check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
      check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_words"}, 32'(words_loaded), 32'd0);
      check_status(tag, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int len;
      ifc.in_data  = 8'h00;
      ifc.in_valid = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_reset_vals("rst");
      rst = 1'b0;
      settle();
      check("rdy_after_rst", 32'(ifc.in_ready), 32'd1);

      // Noise ahead of a sync byte is discarded
      base = wr_cnt;
      send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h3C, 0);
      settle();
      check("noise_nwr", 32'(wr_cnt - base), 32'd0);
      check_status("noise", 1'b1, 1'b0, 1'b0);

      // Nominal frame, with a check of the one-cycle write latency
      base = wr_cnt;
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h01, 0); send_byte(8'h23, 0);
      settle();
      check("lat_we", 32'(mem_we), 32'd1);
      check("lat_waddr", 32'(mem_waddr), 32'd0);
      check("lat_wdata", 32'(mem_wdata), 32'h0123);
      check("lat_words", 32'(words_loaded), 32'd1);
      check("lat_hold", 32'(cpu_hold), 32'd1);
      send_byte(8'h45, 0); send_byte(8'h67, 0);
`ifdef LOADER_CKSUM_EN
      send_byte(8'h00, 0);
`endif
      settle();
      check_nominal("nom", base);
      check_status("nom", 1'b0, 1'b1, 1'b0);

      // Reset in the middle of a frame after one word
      base = wr_cnt;
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h01, 0); send_byte(8'h23, 0);
      settle();
      rst = 1'b1;
      settle();
      check_reset_vals("midrst");
      rst = 1'b0;
      send_byte(8'h45, 0); send_byte(8'h67, 0);
      settle();
      check("midrst_nwr", 32'(wr_cnt - base), 32'd1);
      check("midrst_words", 32'(words_loaded), 32'd0);
      check_status("midrst_idle", 1'b1, 1'b0, 1'b0);

      // Skip in IDLE wins over a same-cycle sync byte
      base = wr_cnt;
      @(negedge clk);
      skip = 1'b1; ifc.in_data = 8'hA5; ifc.in_valid = 1'b1;
      @(posedge clk);
      #1;
      skip = 1'b0; ifc.in_valid = 1'b0;
      settle();
      check_status("skip", 1'b0, 1'b1, 1'b0);
      send_byte(8'h3C, 0);
      settle();
      check("skip_nwr", 32'(wr_cnt - base), 32'd0);
      check_status("skip_ignore", 1'b0, 1'b1, 1'b0);

      // Single-word frame BEEF
      base = wr_cnt;
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
      settle();
      check("beef_we", 32'(mem_we), 32'd1);
      check("beef_waddr", 32'(mem_waddr), 32'd0);
      check("beef_wdata", 32'(mem_wdata), 32'hBEEF);
`ifdef LOADER_CKSUM_EN
      check_status("beef_pre", 1'b1, 1'b0, 1'b0);
      send_byte(8'h51, 0);
      settle();
`endif
      check("beef_nwr", 32'(wr_cnt - base), 32'd1);
      check_status("beef", 1'b0, 1'b1, 1'b0);

      // Count boundaries
      base = wr_cnt;
      send_byte(8'hA5, 0); send_byte(8'h00, 0);
      settle();
      check_status("n0", 1'b1, 1'b0, 1'b1);
      send_byte(8'hA5, 0); send_byte(8'h11, 0);
      settle();
      check_status("n17", 1'b1, 1'b0, 1'b1);
      check("nbad_nwr", 32'(wr_cnt - base), 32'd0);

      // Full-depth frame from ERR: word i = {i, i}, so the payload XOR is 0
      base = wr_cnt;
      fr[0] = 8'hA5; fr[1] = 8'h10;
      for (int i = 0; i < 16; i++) begin
         fr[2 + 2*i] = 8'(i);
         fr[3 + 2*i] = 8'(i);
      end
      len = 34;
`ifdef LOADER_CKSUM_EN
      fr[34] = 8'h00;
      len = 35;
`endif
      send_frame(len, 0);
      settle();
      check("n16_nwr", 32'(wr_cnt - base), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("n16_a%0d", i), 32'(wr_addr[base+i]), 32'(i));
         check($sformatf("n16_d%0d", i), 32'(wr_data[base+i]), 32'(i * 16'h0101));
      end
      check("n16_words", 32'(words_loaded), 32'd16);
      check_status("n16", 1'b0, 1'b1, 1'b0);

`ifdef LOADER_CKSUM_EN
      // Bad checksum: words still written, frame rejected
      base = wr_cnt;
      set_nominal(8'hFF, len);
      send_frame(len, 0);
      settle();
      check("badck_nwr", 32'(wr_cnt - base), 32'd2);
      check_status("badck", 1'b1, 1'b0, 1'b1);
`endif

      // Gapped stream loads the same image
      base = wr_cnt;
      set_nominal(8'h00, len);
      send_frame(len, 1);
      settle();
      check_nominal("gap", base);
      check_status("gap", 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
